// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: elastic FIFO default depth and a matching occupancy type
// for monitoring logic.
package cgra_pkg;

    localparam int ELASTIC_FIFO_DEFAULT_DEPTH = 4;

    typedef logic [$clog2(ELASTIC_FIFO_DEFAULT_DEPTH + 1)-1:0] elastic_cnt_t;

endpackage

// File: rtl/elastic_fifo_mem.sv
// DEPTH x DATA_WIDTH register array for elastic_fifo: one synchronous write port,
// one asynchronous read port, no reset on the storage.
module elastic_fifo_mem
    import cgra_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = ELASTIC_FIFO_DEFAULT_DEPTH,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/elastic_fifo.sv
// Parametrised valid/ready elastic FIFO with stall, synchronous flush and occupancy status.
// Optional zero-latency fall-through when empty: define ELASTIC_FIFO_BYPASS_EN.
module elastic_fifo
    import cgra_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = ELASTIC_FIFO_DEFAULT_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          clr_i,
    input  logic [DATA_WIDTH-1:0]         din_i,
    input  logic                          din_v_i,
    output logic                          din_r_o,
    output logic [DATA_WIDTH-1:0]         dout_o,
    output logic                          dout_v_o,
    input  logic                          dout_r_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("elastic_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  full, empty, active;
    logic                  push, pop, wr_en, rd_en;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign active = en_i && !clr_i && !rst_i;

    // Handshake: a token moves on a side only in a cycle where valid and ready are both
    // high. din_r_o is built from registered occupancy plus the global controls only,
    // so it never depends on dout_r_i and ready chains stay short.
    assign din_r_o = active && !full;
    assign push    = din_v_i && din_r_o;

`ifdef ELASTIC_FIFO_BYPASS_EN
    logic thru;
    assign dout_v_o = active && (!empty || din_v_i);
    assign dout_o   = empty ? din_i : mem_rdata;
    assign pop      = dout_v_o && dout_r_i;
    // An empty-FIFO token taken straight through is never written.
    assign thru     = empty && push && dout_r_i;
    assign wr_en    = push && !thru;
    assign rd_en    = pop && !empty;
`else
    assign dout_v_o = active && !empty;
    assign dout_o   = mem_rdata;
    assign pop      = dout_v_o && dout_r_i;
    assign wr_en    = push;
    assign rd_en    = pop;
`endif

    elastic_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk_i (clk_i),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (din_i),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign full_o  = full;
    assign empty_o = empty;

endmodule

// File: tb/tb_elastic_fifo.sv
// Randomised and directed bench for elastic_fifo against a queue-based reference model.
module tb_elastic_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef ELASTIC_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             en_i = 1'b0;
    logic             clr_i = 1'b0;
    logic [DW-1:0]    din_i = '0;
    logic             din_v_i = 1'b0;
    logic             din_r_o;
    logic [DW-1:0]    dout_o;
    logic             dout_v_o;
    logic             dout_r_i = 1'b0;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             empty_o;

    logic [DW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .din_i    (din_i),
        .din_v_i  (din_v_i),
        .din_r_o  (din_r_o),
        .dout_o   (dout_o),
        .dout_v_o (dout_v_o),
        .dout_r_i (dout_r_i),
        .count_o  (count_o),
        .full_o   (full_o),
        .empty_o  (empty_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs before the rising
    // edge, then advance the reference model by the transfers that edge will perform.
    task automatic cycle(input logic r, input logic c, input logic e, input logic dv,
                         input logic [DW-1:0] d, input logic dr);
        int  sz;
        bit  act, exp_rdy, exp_vld, push, pop;
        @(negedge clk_i);
        rst_i = r; clr_i = c; en_i = e; din_v_i = dv; din_i = d; dout_r_i = dr;
        #2;
        sz      = exp_q.size();
        act     = e && !r && !c;
        exp_rdy = act && (sz < DEPTH);
        exp_vld = act && (sz > 0 || (BYP && dv));
        check("din_r", DW'(din_r_o), DW'(exp_rdy));
        check("dout_v", DW'(dout_v_o), DW'(exp_vld));
        if (exp_vld) check("dout", dout_o, (sz > 0) ? exp_q[0] : d);
        check("count", DW'(count_o), DW'(sz));
        check("full", DW'(full_o), DW'(sz == DEPTH));
        check("empty", DW'(empty_o), DW'(sz == 0));
        if (r || c) begin
            exp_q.delete();
        end else begin
            push = dv && exp_rdy;
            pop  = exp_vld && dr;
            if (!(pop && sz == 0)) begin
                if (pop)  void'(exp_q.pop_front());
                if (push) exp_q.push_back(d);
            end
        end
    endtask

    task automatic push_tok(input logic [DW-1:0] d);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    endtask

    initial begin
        // reset: two unchecked edges, then one checked cycle still in reset
        repeat (2) @(posedge clk_i);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hdead, 1'b1);

        // fill with output stalled, then drain in order
        push_tok(32'h11); push_tok(32'h22); push_tok(32'h33); push_tok(32'h44);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        drain(5);

        // continuous stream, both sides ready
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, DW'(i), 1'b1);
        drain(2);

        // full with simultaneous pop: push refused, accepted next cycle
        for (int i = 0; i < 4; i++) push_tok(DW'(32'h60 + i));
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h99, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h99, 1'b0);
        drain(5);

        // stall with two tokens stored
        push_tok(32'ha1); push_tok(32'ha2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hbb, 1'b1);
        drain(3);

        // flush while pushing, then reset mid-stream
        push_tok(32'hc1); push_tok(32'hc2); push_tok(32'hc3);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h55, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        push_tok(32'hd1); push_tok(32'hd2);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hd3, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);

        // push into empty FIFO with output ready (fall-through when bypass is built)
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hab, 1'b1);
        drain(2);

        // randomised traffic with occasional stall, flush and reset
        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase = (i / 300) % 3;
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) != 0,
                  (phase == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1) == 1,
                  $urandom,
                  (phase == 2) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1) == 1);
        end
        drain(DEPTH + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
